// File: rtl/register_reader_5b.sv
// register_reader_5b: read-side port for a bank of 5-bit registers.
// Accepts an addressed read request, fetches the register slice from the
// flattened bank bus and returns it through a valid/ready handshake.
// Out-of-range addresses return zero with err set. Completed reads are counted.
// Optional build macro READ_BYPASS_EN: forward a same-edge bank write to the read.
//
// State table
//   state   | meaning
//   S_IDLE  | no read in flight, waiting for rd_req
//   S_FETCH | address latched, bank slice captured on this edge
//   S_VALID | result held on rd_data/err until consumer takes it
module register_reader_5b #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_ready,
  input  logic [NUM_REGS*5-1:0] reg_bank,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [4:0]            wr_data,
  output logic                  rd_busy,
  output logic                  rd_valid,
  output logic [4:0]            rd_data,
  output logic                  err,
  output logic [7:0]            rd_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr_q;
  logic                r_busy;
  logic                r_rd_valid;
  logic [4:0]          r_rd_data;
  logic                r_err;
  logic [7:0]          r_rd_count;

  logic                w_in_range;
  logic [4:0]          w_slice;
  logic                w_fwd;
  logic                w_done;

  // Address range check and bank slice mux for the latched address.
  always_comb begin
    w_in_range = (int'(r_addr_q) < NUM_REGS);
    w_slice    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_addr_q == ADDR_W'(i)) w_slice = reg_bank[i*5 +: 5];
    end
  end

`ifdef READ_BYPASS_EN
  // A write landing on the fetched register this edge wins over the stale bank value.
  assign w_fwd = wr_en && (wr_addr == r_addr_q) && w_in_range;
`else
  // Write snoop ports are present but have no effect in this build.
  logic w_unused_snoop;
  assign w_unused_snoop = ^{wr_en, wr_addr, wr_data};
  assign w_fwd = 1'b0;
`endif

  assign w_done = (r_state == S_VALID) && r_rd_valid && rd_ready;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (rd_req) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_VALID;
      S_VALID: if (w_done) w_state_nxt = rd_req ? S_FETCH : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; busy is registered from the next state so it comes off a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Address capture, result register, handshake and completion counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_q   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
      r_rd_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rd_req) r_addr_q <= rd_addr;
        end
        S_FETCH: begin
          if (!w_in_range) begin
            r_rd_data <= 5'd0;
            r_err     <= 1'b1;
          end else begin
            r_rd_data <= w_fwd ? wr_data : w_slice;
            r_err     <= 1'b0;
          end
          r_rd_valid <= 1'b1;
        end
        S_VALID: begin
          if (w_done) begin
            r_rd_count <= r_rd_count + 8'd1;
            r_rd_valid <= 1'b0;
            if (rd_req) r_addr_q <= rd_addr;
          end
        end
        default: begin
          r_rd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rd_busy  = r_busy;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign err      = r_err;
  assign rd_count = r_rd_count;

endmodule

// File: tb/tb_register_reader_5b.sv
// Testbench for register_reader_5b: an 8-register instance for the main
// checks and a 6-register instance sharing the same request stream for the
// out-of-range cases.
module tb_register_reader_5b;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        rd_ready;
  logic [39:0] bank8;
  logic [29:0] bank6;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [4:0]  wr_data;

  logic        busy8, valid8, err8;
  logic [4:0]  data8;
  logic [7:0]  cnt8;
  logic        busy6, valid6, err6;
  logic [4:0]  data6;
  logic [7:0]  cnt6;

  int n_chk  = 0;
  int n_fail = 0;

  logic [4:0] cap_d8, cap_d6;
  logic       cap_e8, cap_e6;

  typedef struct {
    int         addr;
    logic [4:0] val;
    int         wait_cyc;
    logic [4:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  register_reader_5b #(.NUM_REGS(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .reg_bank(bank8), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_busy(busy8), .rd_valid(valid8), .rd_data(data8), .err(err8), .rd_count(cnt8)
  );

  register_reader_5b #(.NUM_REGS(6), .ADDR_W(3)) dut6 (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .reg_bank(bank6), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_busy(busy6), .rd_valid(valid6), .rd_data(data6), .err(err6), .rd_count(cnt6)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank(input int addr, input logic [4:0] val);
    bank8[addr*5 +: 5] = val;
    if (addr < 6) bank6[addr*5 +: 5] = val;
  endtask

  // Single read from IDLE with wcyc cycles of backpressure; result captured
  // when rd_valid first appears and checked for stability during the hold.
  task automatic read_one(input int addr, input int wcyc);
    int c0;
    c0       = int'(cnt8);
    rd_req   = 1'b1;
    rd_addr  = 3'(addr);
    rd_ready = 1'b0;
    tick();
    rd_req  = 1'b0;
    rd_addr = 3'(~addr);
    chk("accept_busy", int'(busy8), 1);
    chk("accept_valid", int'(valid8), 0);
    tick();
    chk("latency_valid", int'(valid8), 1);
    cap_d8 = data8; cap_e8 = err8; cap_d6 = data6; cap_e6 = err6;
    for (int i = 0; i < wcyc; i++) begin
      tick();
      chk("hold_valid", int'(valid8), 1);
      chk("hold_data", int'(data8), int'(cap_d8));
      chk("hold_count", int'(cnt8), c0);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("done_count", int'(cnt8), (c0 + 1) % 256);
    chk("done_valid", int'(valid8), 0);
    chk("done_busy", int'(busy8), 0);
  endtask

  initial begin
    int base;
    int cyc;

    vecs[0] = '{3, 5'h15, 0, 5'h15, 1'b0};
    vecs[1] = '{1, 5'h0A, 1, 5'h0A, 1'b0};
    vecs[2] = '{0, 5'h01, 0, 5'h01, 1'b0};
    vecs[3] = '{7, 5'h1F, 2, 5'h1F, 1'b0};
    vecs[4] = '{5, 5'h00, 0, 5'h00, 1'b0};
    vecs[5] = '{6, 5'h11, 3, 5'h11, 1'b0};

    rst = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    bank8 = '0; bank6 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(valid8), 0);
    chk("rst_data", int'(data8), 0);
    chk("rst_err", int'(err8), 0);
    chk("rst_count", int'(cnt8), 0);
    chk("rst_busy", int'(busy8), 0);
    rst = 1'b1;
    tick();
    chk("post_rst_busy", int'(busy8), 0);

    // Table-driven reads
    for (int v = 0; v < 6; v++) begin
      set_bank(vecs[v].addr, vecs[v].val);
      read_one(vecs[v].addr, vecs[v].wait_cyc);
      chk("vec_data", int'(cap_d8), int'(vecs[v].exp_data));
      chk("vec_err", int'(cap_e8), int'(vecs[v].exp_err));
    end
    chk("vec_total_count", int'(cnt8), 6);

    // Backpressure with bank change during hold
    set_bank(1, 5'h0A);
    base     = int'(cnt8);
    rd_req   = 1'b1; rd_addr = 3'd1; rd_ready = 1'b0;
    tick();
    rd_req = 1'b0;
    tick();
    set_bank(1, 5'h1F);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", int'(valid8), 1);
      chk("bp_data", int'(data8), 'h0A);
      chk("bp_count", int'(cnt8), base);
      tick();
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("bp_count_after", int'(cnt8), base + 1);

    // Back-to-back reads 0,2,7 with rd_req held high
    set_bank(0, 5'h01); set_bank(2, 5'h02); set_bank(7, 5'h07);
    base     = int'(cnt8);
    rd_ready = 1'b1; rd_req = 1'b1; rd_addr = 3'd0;
    tick();
    tick();
    chk("b2b_valid0", int'(valid8), 1);
    chk("b2b_data0", int'(data8), 'h01);
    rd_addr = 3'd2;
    tick();
    chk("b2b_busy_gap", int'(busy8), 1);
    chk("b2b_valid_gap", int'(valid8), 0);
    tick();
    chk("b2b_data1", int'(data8), 'h02);
    rd_addr = 3'd7;
    tick();
    chk("b2b_busy_gap2", int'(busy8), 1);
    tick();
    chk("b2b_data2", int'(data8), 'h07);
    rd_req = 1'b0;
    tick();
    rd_ready = 1'b0;
    chk("b2b_count", int'(cnt8), base + 3);
    chk("b2b_idle", int'(busy8), 0);

    // Out-of-range on the 6-register instance
    read_one(7, 0);
    chk("oor7_data6", int'(cap_d6), 0);
    chk("oor7_err6", int'(cap_e6), 1);
    chk("oor7_err8", int'(cap_e8), 0);
    read_one(6, 1);
    chk("oor6_data6", int'(cap_d6), 0);
    chk("oor6_err6", int'(cap_e6), 1);
    set_bank(0, 5'h09);
    read_one(0, 0);
    chk("reg0_data6", int'(cap_d6), 'h09);
    chk("reg0_err6", int'(cap_e6), 0);
    set_bank(5, 5'h13);
    read_one(5, 0);
    chk("reg5_data6", int'(cap_d6), 'h13);
    chk("reg5_err6", int'(cap_e6), 0);

    // Forwarding of a same-edge write
    set_bank(4, 5'h03);
    rd_req = 1'b1; rd_addr = 3'd4; rd_ready = 1'b0;
    tick();
    rd_req = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 5'h1C;
    tick();
    wr_en = 1'b0;
`ifdef READ_BYPASS_EN
    chk("bypass_hit", int'(data8), 'h1C);
`else
    chk("bypass_hit", int'(data8), 'h03);
`endif
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    rd_req = 1'b1; rd_addr = 3'd4;
    tick();
    rd_req = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 5'h1C;
    tick();
    wr_en = 1'b0;
    chk("bypass_miss", int'(data8), 'h03);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;

    // Reset while holding a result
    set_bank(2, 5'h16);
    rd_req = 1'b1; rd_addr = 3'd2;
    tick();
    rd_req = 1'b0;
    tick();
    chk("mid_pre_valid", int'(valid8), 1);
    chk("mid_pre_data", int'(data8), 'h16);
    rst = 1'b0;
    #1;
    chk("mid_valid", int'(valid8), 0);
    chk("mid_data", int'(data8), 0);
    chk("mid_err", int'(err8), 0);
    chk("mid_busy", int'(busy8), 0);
    chk("mid_count", int'(cnt8), 0);
    chk("mid_valid6", int'(valid6), 0);
    rd_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("mid_after_count", int'(cnt8), 0);
    chk("mid_after_busy", int'(busy8), 0);

    // Counter wrap after 256 completions
    rd_ready = 1'b1; rd_req = 1'b1; rd_addr = 3'd3;
    cyc = 0;
    while (cnt8 != 8'd255 && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("wrap_reach_255", int'(cnt8), 255);
    rd_req = 1'b0;
    tick();
    tick();
    rd_ready = 1'b0;
    chk("wrap_count", int'(cnt8), 0);
    chk("wrap_count6", int'(cnt6), 0);
    chk("wrap_idle", int'(busy8), 0);
    chk("wrap_idle6", int'(busy6), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
